// File: rtl/lpf_pkg.sv
// Shared constants for the low-pass filter output path and its decimator.
package lpf_pkg;

  localparam int unsigned LPF_OUT_W   = 13;
  localparam int unsigned DECIM_LOG2  = 2;
  localparam int unsigned DECIM_N     = 1 << DECIM_LOG2;
  localparam int unsigned DECIM_ACC_W = LPF_OUT_W + DECIM_LOG2;
  localparam int unsigned DECIM_RND   = 1 << (DECIM_LOG2 - 1);

endpackage

// File: rtl/decim_fifo2.sv
// Two-entry FIFO with a registered head; the head reads zero when empty.
module decim_fifo2 #(
  parameter int unsigned width = 13
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [width-1:0] i_data,
  input  logic             i_pop,
  output logic [width-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  logic [width-1:0] r_head, w_head_d;
  logic [width-1:0] r_tail, w_tail_d;
  logic [1:0]       r_count, w_count_d;
  logic             w_pop_eff, w_push_eff;

  assign o_full     = (r_count == 2'd2);
  assign o_empty    = (r_count == 2'd0);
  assign w_pop_eff  = i_pop & ~o_empty;
  // A push into a full queue only lands when the head leaves on the same edge.
  assign w_push_eff = i_push & (~o_full | w_pop_eff);

  always_comb begin
    w_head_d  = r_head;
    w_tail_d  = r_tail;
    w_count_d = r_count;
    if (w_pop_eff && w_push_eff) begin
      if (r_count == 2'd1) begin
        w_head_d = i_data;
      end else begin
        w_head_d = r_tail;
        w_tail_d = i_data;
      end
    end else if (w_pop_eff) begin
      w_head_d  = (r_count == 2'd2) ? r_tail : '0;
      w_count_d = r_count - 2'd1;
    end else if (w_push_eff) begin
      if (r_count == 2'd0) begin
        w_head_d = i_data;
      end else begin
        w_tail_d = i_data;
      end
      w_count_d = r_count + 2'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= 2'd0;
    end else begin
      r_head  <= w_head_d;
      r_tail  <= w_tail_d;
      r_count <= w_count_d;
    end
  end

  assign o_data = r_head;

endmodule

// File: rtl/lpf_decim.sv
// Accumulate-and-dump decimator behind the low-pass biquad: averages blocks of
// 2^decim_log2 samples with round-half-up and queues results for a valid/ready consumer.
module lpf_decim
  import lpf_pkg::*;
#(
  parameter int unsigned in_width   = LPF_OUT_W - 1,
  parameter int unsigned decim_log2 = DECIM_LOG2
) (
  input  logic                     I_clk,
  input  logic                     I_reset_n,
  input  logic signed [in_width:0] I_data,
  input  logic                     I_valid,
  input  logic                     I_sync,
  output logic signed [in_width:0] O_data,
  output logic                     O_valid,
  input  logic                     I_ready,
  output logic                     O_overrun
);

  localparam int unsigned DATA_W = in_width + 1;
  localparam int unsigned ACC_W  = in_width + 1 + decim_log2;
  localparam logic signed [ACC_W-1:0] RND = ACC_W'(64'd1 << (decim_log2 - 1));

  logic signed [ACC_W-1:0]  r_acc, w_acc_d;
  logic signed [ACC_W-1:0]  w_data_ext, w_sum;
  logic [decim_log2-1:0]    r_cnt, w_cnt_d;
  logic signed [DATA_W-1:0] w_result;
  logic [DATA_W-1:0]        w_head;
  logic                     w_last, w_push, w_pop, w_full, w_empty;
  logic                     r_overrun;

  assign w_data_ext = {{decim_log2{I_data[in_width]}}, I_data};
  assign w_sum      = r_acc + w_data_ext;
  assign w_last     = &r_cnt;
  // The block sum plus N/2 never exceeds the accumulator range, so no guard bit is needed.
  assign w_result   = DATA_W'((w_sum + RND) >>> decim_log2);

  always_comb begin
    w_acc_d = r_acc;
    w_cnt_d = r_cnt;
    w_push  = 1'b0;
    if (I_sync) begin
      if (I_valid) begin
        w_acc_d = w_data_ext;
        w_cnt_d = decim_log2'(1);
      end else begin
        w_acc_d = '0;
        w_cnt_d = '0;
      end
    end else if (I_valid) begin
      if (w_last) begin
        w_acc_d = '0;
        w_cnt_d = '0;
        w_push  = 1'b1;
      end else begin
        w_acc_d = w_sum;
        w_cnt_d = r_cnt + decim_log2'(1);
      end
    end
  end

  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      r_acc     <= '0;
      r_cnt     <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_acc     <= w_acc_d;
      r_cnt     <= w_cnt_d;
      r_overrun <= w_push & w_full & ~w_pop;
    end
  end

  assign w_pop = ~w_empty & I_ready;

  decim_fifo2 #(
    .width(DATA_W)
  ) u_fifo (
    .i_clk   (I_clk),
    .i_rst_n (I_reset_n),
    .i_push  (w_push),
    .i_data  (w_result),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign O_data    = w_head;
  assign O_valid   = ~w_empty;
  assign O_overrun = r_overrun;

endmodule

// File: doc/lpf_decim.md
Name: lpf_decim

Overview:
Downstream neighbour of the 2nd-order low-pass biquad. Consumes the filter's 13-bit signed output stream and decimates it by 2^decim_log2 using accumulate-and-dump averaging with round-half-up. Results are buffered in a 2-entry output queue with a valid/ready handshake toward the next consumer. Phase can be realigned with a sync strobe, and dropped results are flagged.

Parameters:
in_width, 12, data MSB index; data ports are in_width+1 bits, signed two's complement
decim_log2, 2, log2 of the decimation factor N; N = 2^decim_log2; legal range is at least 1

Ports:
I_clk  input  1  clock, all state on the rising edge
I_reset_n  input  1  asynchronous, active-low reset
I_data  input  in_width+1  signed sample from the low-pass filter
I_valid  input  1  I_data is a sample this cycle
I_sync  input  1  restart the decimation phase; clears the partial accumulation
O_data  output  in_width+1  signed decimated sample, head of the output queue
O_valid  output  1  O_data holds a result
I_ready  input  1  consumer accepts O_data this cycle
O_overrun  output  1  one-cycle pulse: a result was dropped because the queue was full

Behaviour:
- Reset (I_reset_n low, asynchronous): acc=0, cnt=0, queue empty, O_valid=0, O_data=0, O_overrun=0. Holds until the first rising edge after release.
- Accumulator acc: signed, in_width+1+decim_log2 bits; cannot overflow. Counter cnt: decim_log2 bits.
- On a rising edge with I_valid=1 and I_sync=0:
  - cnt<N-1: acc <= acc+I_data; cnt <= cnt+1.
  - cnt==N-1: sum = acc+I_data. Result = (sum + 2^(decim_log2-1)) >>> decim_log2, arithmetic shift, which equals floor(sum/N + 0.5). Result always fits in in_width+1 bits, so no saturation is needed. Push the result; acc <= 0; cnt <= 0.
- I_sync=1: acc and cnt clear.
  - If I_valid=1 in the same cycle, that sample starts the new block: acc <= I_data, cnt <= 1.
  - For N=2 this does not push a result.
  - I_sync never affects the queue.
- I_valid=0 and I_sync=0: acc and cnt hold.
- Latency: O_valid rises on the edge that consumes the N-th sample, so the result is visible in the following cycle.
- Queue: 2 entries, FIFO order.
  - O_valid = not empty. O_data = head entry, registered; O_data=0 when empty.
  - Pop on O_valid && I_ready at the edge.
  - Push and pop in the same cycle are legal at any occupancy, including full; no drop in that case.
  - Push when full without a pop: the new result is discarded, the queue is unchanged, and O_overrun=1 for exactly the next cycle.
  - Pop when empty is ignored.
- O_data stays stable while O_valid && !I_ready.
- Reset mid-block or mid-queue discards everything. After release, the first output requires N fresh samples.

Decomposition:
- Shared package lpf_pkg holds these constants:
  - LPF_OUT_W = 13, the filter output width, equal to in_width+1.
  - DECIM_N.
  - DECIM_ACC_W = in_width+1+decim_log2.
  - The round constant.
- One sub-module, decim_fifo2: a parameterised-width 2-entry FIFO with push, pop, full, empty and registered head. It is instantiated once.
- The accumulate, round and sync logic stays in lpf_decim.

Test Plan:
All scenarios use N=4 and in_width=12.
1. I_valid=1, I_data 100,101,102,103, I_ready=1 -> sum 406; one cycle after the 4th edge, O_valid=1 and O_data=102 for one cycle.
2. Rounding and full scale:
   - -1,-1,-1,-2 -> O_data=-1.
   - 4x -4096 -> -4096.
   - 4x 4095 -> 4095.
   - 1,1,0,0 -> 1 (0.5 rounds up).
   - -1,-1,0,0 -> 0.
3. Backpressure: I_ready=0, continuous I_valid with data 8 for 12 samples -> two results queued (8,8); the 3rd result gives an O_overrun pulse and O_data is unchanged. Raising I_ready pops 8 then 8, then O_valid=0.
4. Queue full with I_ready=1 on the same edge as the 3rd push -> no O_overrun; occupancy stays 2, order preserved.
5. Sync realignment: samples 500,500, then I_sync=1 with I_valid=1 and data 40, then 40,40,40 -> a single output of 40, emitted after the 4th sample of the new block. Also check I_sync with I_valid=0 mid-block.
6. Async reset mid-operation: assert I_reset_n low between clock edges while the queue holds 1 entry and cnt=2 -> O_valid=0 and O_data=0 immediately. After release, 3 samples give no output; the 4th produces the average of the fresh samples only.
